associative_data_array_arbiter: RTL and testbench

Shares one associative_data_array between NUMBER_REQUESTERS clients using round-robin arbitration with per-requester valid/ready handshakes. Drives the array command port and routes read data back to the issuing requester. After reset it sequences a zero-initialisation sweep over every set before accepting any traffic. Sits between cache pipeline clients (lookup, refill, snoop) and the data array.

---
 rtl/associative_data_array_pkg.sv | 28 ++
 rtl/associative_data_array_arbiter_rr.sv | 47 ++++
 rtl/associative_data_array_arbiter.sv | 172 +++++++++++++++++
 tb/tb_associative_data_array_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/associative_data_array_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// associative_data_array_pkg : geometry defaults, FSM state and request type
// Rev 1.0
// ----------------------------------------------------------------------------
package associative_data_array_pkg;

   localparam int c_SINGLE_ELEMENT_SIZE_IN_BITS = 64;
   localparam int c_NUMBER_SETS                 = 64;
   localparam int c_NUMBER_WAYS                 = 16;
   localparam int c_SET_PTR_WIDTH_IN_BITS       = $clog2(c_NUMBER_SETS);
   localparam int c_NUMBER_REQUESTERS           = 4;

   typedef enum logic [0:0] {
      INIT  = 1'b0,
      SERVE = 1'b1
   } arb_state_t;

   // Request layout for the default array geometry
   typedef struct packed {
      logic                                    write;
      logic [c_SET_PTR_WIDTH_IN_BITS-1:0]      set_addr;
      logic [c_NUMBER_WAYS-1:0]                way_select;
      logic [c_SINGLE_ELEMENT_SIZE_IN_BITS-1:0] write_data;
   } array_req_t;

endpackage
`default_nettype wire

// File: rtl/associative_data_array_arbiter_rr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// round_robin_arbiter : rotating-priority one-hot grant with pointer register
// Rev 1.0
// ----------------------------------------------------------------------------
module round_robin_arbiter #(
   parameter int NUMBER_REQUESTERS     = 4,
   parameter int REQ_PTR_WIDTH_IN_BITS = $clog2(NUMBER_REQUESTERS)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUMBER_REQUESTERS-1:0]     i_request,
   input  logic                             i_update,
   output logic [NUMBER_REQUESTERS-1:0]     o_grant,
   output logic [REQ_PTR_WIDTH_IN_BITS-1:0] o_grant_id
);

   logic [REQ_PTR_WIDTH_IN_BITS-1:0] r_ptr;
   logic [REQ_PTR_WIDTH_IN_BITS-1:0] w_idx;
   logic                             w_found;

   // Scan starts one past the last winner so the last winner has lowest priority
   always_comb begin
      o_grant    = '0;
      o_grant_id = r_ptr;
      w_found    = 1'b0;
      w_idx      = '0;
      for (int k = 1; k <= NUMBER_REQUESTERS; k++) begin
         w_idx = REQ_PTR_WIDTH_IN_BITS'((int'(r_ptr) + k) % NUMBER_REQUESTERS);
         if (!w_found && i_request[w_idx]) begin
            w_found        = 1'b1;
            o_grant[w_idx] = 1'b1;
            o_grant_id     = w_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= REQ_PTR_WIDTH_IN_BITS'(NUMBER_REQUESTERS - 1);
      end else if (i_update) begin
         r_ptr <= o_grant_id;
      end
   end

endmodule
`default_nettype wire

// File: rtl/associative_data_array_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// associative_data_array_arbiter : shares one data array among N clients
// Rev 1.0
// ----------------------------------------------------------------------------
module associative_data_array_arbiter
   import associative_data_array_pkg::*;
#(
   parameter int SINGLE_ELEMENT_SIZE_IN_BITS = c_SINGLE_ELEMENT_SIZE_IN_BITS,
   parameter int NUMBER_SETS                 = c_NUMBER_SETS,
   parameter int NUMBER_WAYS                 = c_NUMBER_WAYS,
   parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS),
   parameter int NUMBER_REQUESTERS           = c_NUMBER_REQUESTERS,
   parameter int REQ_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_REQUESTERS)
) (
   input  logic                                                 clk_in,
   input  logic                                                 reset_in,
   input  logic [NUMBER_REQUESTERS-1:0]                         request_valid_in,
   output logic [NUMBER_REQUESTERS-1:0]                         request_ready_out,
   input  logic [NUMBER_REQUESTERS-1:0]                         request_write_in,
   input  logic [NUMBER_REQUESTERS*SET_PTR_WIDTH_IN_BITS-1:0]   request_set_addr_in,
   input  logic [NUMBER_REQUESTERS*NUMBER_WAYS-1:0]             request_way_select_in,
   input  logic [NUMBER_REQUESTERS*SINGLE_ELEMENT_SIZE_IN_BITS-1:0] request_write_data_in,
   output logic [NUMBER_REQUESTERS-1:0]                         response_valid_out,
   output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]               response_single_element_out,
   output logic [SINGLE_ELEMENT_SIZE_IN_BITS*NUMBER_WAYS-1:0]   response_set_element_out,
   output logic                                                 error_out,
   output logic                                                 init_done_out,
   output logic                                                 array_access_en_out,
   output logic                                                 array_write_en_out,
   output logic [SET_PTR_WIDTH_IN_BITS-1:0]                     array_set_addr_out,
   output logic [NUMBER_WAYS-1:0]                               array_way_select_out,
   output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]               array_write_data_out,
   input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]               array_read_single_element_in,
   input  logic [SINGLE_ELEMENT_SIZE_IN_BITS*NUMBER_WAYS-1:0]   array_read_set_element_in
);

   // One extra count value marks the idle cycle after the last set is written
   localparam int c_INIT_CNT_W = SET_PTR_WIDTH_IN_BITS + 1;

   typedef struct packed {
      logic                                   write;
      logic [SET_PTR_WIDTH_IN_BITS-1:0]       set_addr;
      logic [NUMBER_WAYS-1:0]                 way_select;
      logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] write_data;
   } cmd_t;

   arb_state_t                       r_state;
   arb_state_t                       w_state_nxt;
   logic [c_INIT_CNT_W-1:0]          r_init_cnt;
   logic                             w_init_last;
   logic                             w_serve;
   logic                             w_hs;
   logic                             w_illegal;
   logic [NUMBER_REQUESTERS-1:0]     w_grant;
   logic [REQ_PTR_WIDTH_IN_BITS-1:0] w_grant_id;
   cmd_t                             w_req;

   logic                                   r_access_en;
   logic                                   r_write_en;
   logic [SET_PTR_WIDTH_IN_BITS-1:0]       r_set_addr;
   logic [NUMBER_WAYS-1:0]                 r_way_select;
   logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] r_write_data;
   logic                                   r_err;
   logic                                   r_rd_v1;
   logic [REQ_PTR_WIDTH_IN_BITS-1:0]       r_rd_id1;
   logic [NUMBER_REQUESTERS-1:0]           r_rsp_valid;

   round_robin_arbiter #(
      .NUMBER_REQUESTERS     (NUMBER_REQUESTERS),
      .REQ_PTR_WIDTH_IN_BITS (REQ_PTR_WIDTH_IN_BITS)
   ) u_rr (
      .clk        (clk_in),
      .rst_n      (reset_in),
      .i_request  (request_valid_in),
      .i_update   (w_hs),
      .o_grant    (w_grant),
      .o_grant_id (w_grant_id)
   );

   assign w_init_last = (r_init_cnt == c_INIT_CNT_W'(NUMBER_SETS));

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         r_state <= INIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         INIT:    if (w_init_last) w_state_nxt = SERVE;
         SERVE:   w_state_nxt = SERVE;
         default: w_state_nxt = INIT;
      endcase
   end

   always_comb begin
      w_serve           = (r_state == SERVE);
      request_ready_out = w_serve ? w_grant : '0;
      init_done_out     = w_serve;
   end

   assign w_hs = |(request_valid_in & request_ready_out);

   always_comb begin
      w_req.write      = request_write_in[w_grant_id];
      w_req.set_addr   = request_set_addr_in[w_grant_id*SET_PTR_WIDTH_IN_BITS +: SET_PTR_WIDTH_IN_BITS];
      w_req.way_select = request_way_select_in[w_grant_id*NUMBER_WAYS +: NUMBER_WAYS];
      w_req.write_data = request_write_data_in[w_grant_id*SINGLE_ELEMENT_SIZE_IN_BITS +: SINGLE_ELEMENT_SIZE_IN_BITS];
      w_illegal        = w_req.write && (w_req.way_select == '0);
   end

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         r_init_cnt   <= '0;
         r_access_en  <= 1'b0;
         r_write_en   <= 1'b0;
         r_set_addr   <= '0;
         r_way_select <= '0;
         r_write_data <= '0;
         r_err        <= 1'b0;
         r_rd_v1      <= 1'b0;
         r_rd_id1     <= '0;
         r_rsp_valid  <= '0;
      end else begin
         r_access_en <= 1'b0;
         r_err       <= 1'b0;
         r_rd_v1     <= w_hs && !w_req.write;
         r_rd_id1    <= w_grant_id;
         r_rsp_valid <= '0;
         if (r_rd_v1) begin
            r_rsp_valid[r_rd_id1] <= 1'b1;
         end
         if (r_state == INIT) begin
            if (!w_init_last) begin
               r_access_en  <= 1'b1;
               r_write_en   <= 1'b1;
               r_set_addr   <= r_init_cnt[SET_PTR_WIDTH_IN_BITS-1:0];
               r_way_select <= '1;
               r_write_data <= '0;
               r_init_cnt   <= r_init_cnt + c_INIT_CNT_W'(1);
            end
         end else if (w_hs) begin
            // Zero-mask writes are acknowledged but never reach the array
            if (w_illegal) begin
               r_err <= 1'b1;
            end else begin
               r_access_en  <= 1'b1;
               r_write_en   <= w_req.write;
               r_set_addr   <= w_req.set_addr;
               r_way_select <= w_req.way_select;
               r_write_data <= w_req.write_data;
            end
         end
      end
   end

   assign array_access_en_out         = r_access_en;
   assign array_write_en_out          = r_write_en;
   assign array_set_addr_out          = r_set_addr;
   assign array_way_select_out        = r_way_select;
   assign array_write_data_out        = r_write_data;
   assign error_out                   = r_err;
   assign response_valid_out          = r_rsp_valid;
   assign response_single_element_out = array_read_single_element_in;
   assign response_set_element_out    = array_read_set_element_in;

endmodule
`default_nettype wire

// File: tb/tb_associative_data_array_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_associative_data_array_arbiter : scoreboard bench with a behavioural array
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_associative_data_array_arbiter;

   localparam int NR = 4;
   localparam int NS = 64;
   localparam int NW = 16;
   localparam int EW = 64;
   localparam int SW = 6;

   localparam logic [EW-1:0] DATA_A = 64'hDEADBEEF_CAFEF00D;
   localparam logic [EW-1:0] DATA_B = 64'h12345678_9ABCDEF0;
   localparam logic [EW-1:0] DATA_C = 64'hFFFF0000_5555AAAA;

   logic               clk_in = 1'b0;
   logic               reset_in;
   logic [NR-1:0]      request_valid_in;
   logic [NR-1:0]      request_ready_out;
   logic [NR-1:0]      request_write_in;
   logic [NR*SW-1:0]   request_set_addr_in;
   logic [NR*NW-1:0]   request_way_select_in;
   logic [NR*EW-1:0]   request_write_data_in;
   logic [NR-1:0]      response_valid_out;
   logic [EW-1:0]      response_single_element_out;
   logic [EW*NW-1:0]   response_set_element_out;
   logic               error_out;
   logic               init_done_out;
   logic               array_access_en_out;
   logic               array_write_en_out;
   logic [SW-1:0]      array_set_addr_out;
   logic [NW-1:0]      array_way_select_out;
   logic [EW-1:0]      array_write_data_out;
   logic [EW-1:0]      array_read_single_element_in;
   logic [EW*NW-1:0]   array_read_set_element_in;

   associative_data_array_arbiter dut (
      .clk_in                       (clk_in),
      .reset_in                     (reset_in),
      .request_valid_in             (request_valid_in),
      .request_ready_out            (request_ready_out),
      .request_write_in             (request_write_in),
      .request_set_addr_in          (request_set_addr_in),
      .request_way_select_in        (request_way_select_in),
      .request_write_data_in        (request_write_data_in),
      .response_valid_out           (response_valid_out),
      .response_single_element_out  (response_single_element_out),
      .response_set_element_out     (response_set_element_out),
      .error_out                    (error_out),
      .init_done_out                (init_done_out),
      .array_access_en_out          (array_access_en_out),
      .array_write_en_out           (array_write_en_out),
      .array_set_addr_out           (array_set_addr_out),
      .array_way_select_out         (array_way_select_out),
      .array_write_data_out         (array_write_data_out),
      .array_read_single_element_in (array_read_single_element_in),
      .array_read_set_element_in    (array_read_set_element_in)
   );

   always #5 clk_in = ~clk_in;

   // Behavioural data array: samples the command at the clock edge, read data next cycle
   logic [EW-1:0] mem [NS][NW];
   logic [EW-1:0] rd_tmp;
   always @(posedge clk_in) begin
      if (array_access_en_out) begin
         if (array_write_en_out) begin
            for (int w = 0; w < NW; w++)
               if (array_way_select_out[w]) mem[array_set_addr_out][w] <= array_write_data_out;
         end else begin
            rd_tmp = '0;
            for (int w = 0; w < NW; w++) begin
               if (array_way_select_out[w]) rd_tmp = rd_tmp | mem[array_set_addr_out][w];
               array_read_set_element_in[w*EW +: EW] <= mem[array_set_addr_out][w];
            end
            array_read_single_element_in <= rd_tmp;
         end
      end
   end

   typedef struct {
      int               id;
      int               due;
      logic [EW-1:0]    single;
      bit               chk_set;
      logic [EW*NW-1:0] setv;
   } exp_t;

   exp_t             sb[$];
   int               gnt_log[$];
   int               cyc = 0;
   int               n_checks = 0;
   int               n_pass = 0;
   bit               sb_push_en;
   logic [NR-1:0]    hold;
   logic [EW-1:0]    exp_single [NR];
   bit               exp_chk    [NR];
   logic [EW*NW-1:0] exp_setv   [NR];

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [EW*NW-1:0] one_way(input int w, input logic [EW-1:0] d);
      logic [EW*NW-1:0] r;
      r = '0;
      r[w*EW +: EW] = d;
      return r;
   endfunction

   // Monitor: pops the scoreboard whenever a response strobe appears
   always @(negedge clk_in) begin
      exp_t e;
      if (response_valid_out != '0) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp", response_valid_out, '0);
         end else begin
            e = sb.pop_front();
            chk("rsp_valid", response_valid_out, (1 << e.id));
            chk("rsp_latency", cyc, e.due);
            chk("rsp_single", response_single_element_out, e.single);
            if (e.chk_set) chk("rsp_set", response_set_element_out, e.setv);
         end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         chk("rsp_missing", response_valid_out, (1 << e.id));
      end
   end

   task automatic run_cycle(output logic [NR-1:0] hsm);
      exp_t e;
      @(negedge clk_in);
      hsm = request_valid_in & request_ready_out;
      chk("ready_onehot", ($countones(request_ready_out) <= 1), 1'b1);
      for (int i = 0; i < NR; i++) begin
         if (hsm[i]) begin
            gnt_log.push_back(i);
            if (!request_write_in[i] && sb_push_en) begin
               e.id = i; e.due = cyc + 2; e.single = exp_single[i];
               e.chk_set = exp_chk[i]; e.setv = exp_setv[i];
               sb.push_back(e);
            end
         end
      end
      @(posedge clk_in); #1;
      for (int i = 0; i < NR; i++)
         if (hsm[i] && !hold[i]) request_valid_in[i] = 1'b0;
   endtask

   task automatic set_req(input int id, input logic wr, input logic [SW-1:0] s, input logic [NW-1:0] m,
                          input logic [EW-1:0] d, input logic [EW-1:0] es, input bit ck,
                          input logic [EW*NW-1:0] ev);
      request_write_in[id]              = wr;
      request_set_addr_in[id*SW +: SW]  = s;
      request_way_select_in[id*NW +: NW] = m;
      request_write_data_in[id*EW +: EW] = d;
      exp_single[id]                    = es;
      exp_chk[id]                       = ck;
      exp_setv[id]                      = ev;
      request_valid_in[id]              = 1'b1;
   endtask

   task automatic issue(input int id, input logic wr, input logic [SW-1:0] s, input logic [NW-1:0] m,
                        input logic [EW-1:0] d, input logic [EW-1:0] es, input bit ck,
                        input logic [EW*NW-1:0] ev);
      logic [NR-1:0] hsm;
      bit done;
      done = 1'b0;
      set_req(id, wr, s, m, d, es, ck, ev);
      for (int k = 0; k < 8 && !done; k++) begin
         run_cycle(hsm);
         if (hsm[id]) done = 1'b1;
      end
      if (!done) begin
         chk("hs_timeout", 1'b0, 1'b1);
         request_valid_in[id] = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic init_check();
      @(posedge clk_in);
      for (int c = 0; c < NS; c++) begin
         @(negedge clk_in);
         chk("init_sweep",
             {array_access_en_out, array_write_en_out, array_set_addr_out, array_way_select_out,
              array_write_data_out, request_ready_out, init_done_out},
             {1'b1, 1'b1, 6'(c), 16'hFFFF, 64'h0, 4'h0, 1'b0});
      end
      @(negedge clk_in);
      chk("init_done", {array_access_en_out, init_done_out}, 2'b01);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NR-1:0] hsm;
      int exp_order[6];
      exp_order = '{0, 1, 2, 3, 0, 1};
      reset_in = 1'b0;
      request_valid_in = '0; request_write_in = '0; request_set_addr_in = '0;
      request_way_select_in = '0; request_write_data_in = '0;
      hold = '0; sb_push_en = 1'b1;
      for (int i = 0; i < NR; i++) begin
         exp_single[i] = '0; exp_chk[i] = 1'b0; exp_setv[i] = '0;
      end

      repeat (2) @(posedge clk_in);
      #1;
      chk("reset_outputs",
          {request_ready_out, response_valid_out, error_out, init_done_out, array_access_en_out,
           array_write_en_out, array_set_addr_out, array_way_select_out, array_write_data_out}, '0);
      @(negedge clk_in);
      reset_in = 1'b1;
      init_check();
      @(posedge clk_in); #1;

      // Write then read back one way of set 5
      issue(0, 1'b1, 6'd5, 16'h0008, DATA_A, '0, 1'b0, '0);
      idle(2);
      issue(0, 1'b0, 6'd5, 16'h0008, '0, DATA_A, 1'b1, one_way(3, DATA_A));
      idle(3);
      issue(3, 1'b0, 6'd5, 16'h0008, '0, DATA_A, 1'b1, one_way(3, DATA_A));
      idle(3);

      // All clients reading continuously: priority rotates from client 0
      gnt_log.delete();
      for (int i = 0; i < NR; i++) set_req(i, 1'b0, 6'd5, 16'h0008, '0, DATA_A, 1'b1, one_way(3, DATA_A));
      hold = '1;
      for (int k = 0; k < 6; k++) begin
         run_cycle(hsm);
         chk("rr_one_hs_per_cycle", $countones(hsm), 1);
      end
      hold = '0;
      request_valid_in = '0;
      chk("rr_count", gnt_log.size(), 6);
      for (int k = 0; k < 6 && k < gnt_log.size(); k++) chk("rr_order", gnt_log[k], exp_order[k]);
      idle(4);

      // Write in T, read the same location in T+1
      issue(2, 1'b1, 6'd9, 16'h0004, DATA_B, '0, 1'b0, '0);
      issue(2, 1'b0, 6'd9, 16'h0004, '0, DATA_B, 1'b1, one_way(2, DATA_B));
      idle(4);

      // Zero-mask write is acknowledged, dropped, and flagged
      issue(1, 1'b1, 6'd12, 16'h0000, DATA_C, '0, 1'b0, '0);
      @(negedge clk_in);
      chk("err_pulse", {error_out, array_access_en_out}, 2'b10);
      @(negedge clk_in);
      chk("err_single_cycle", error_out, 1'b0);
      @(posedge clk_in); #1;
      issue(1, 1'b0, 6'd12, 16'h0001, '0, 64'h0, 1'b1, '0);
      idle(4);

      // Reset one cycle after a read handshake: response must never appear
      sb_push_en = 1'b0;
      issue(0, 1'b0, 6'd5, 16'h0008, '0, DATA_A, 1'b1, one_way(3, DATA_A));
      reset_in = 1'b0;
      #1;
      chk("async_reset_outputs",
          {request_ready_out, response_valid_out, error_out, init_done_out, array_access_en_out,
           array_write_en_out, array_set_addr_out, array_way_select_out, array_write_data_out}, '0);
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      reset_in = 1'b1;
      sb_push_en = 1'b1;
      init_check();
      @(posedge clk_in); #1;

      // The sweep has cleared set 5 again
      issue(0, 1'b0, 6'd5, 16'h0008, '0, 64'h0, 1'b1, '0);
      idle(4);

      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
